register_file_2r1w: RTL
=======================

REGISTER_FILE_2R1W -- requirements
Module: register_file_2r1w

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 8, data word width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port wr_valid  input  1  write-back request this cycle.
REQ-005 SHALL have port wr_sel  input  3  destination register index 0-7.
REQ-006 SHALL have port wr_data  input  WORD_SIZE  write-back value (ALU result).
REQ-007 SHALL have port lock_valid  input  1  issue request reserving a destination register.
REQ-008 SHALL have port lock_sel  input  3  register index to reserve.
REQ-009 SHALL have port lock_ready  output  1  lock accepted this cycle.
REQ-010 SHALL have port rd_a_sel  input  3  ALU side-A source index 0-7.
REQ-011 SHALL have port rd_a_data  output  WORD_SIZE  side-A operand.
REQ-012 SHALL have port rd_a_ready  output  1  side-A operand valid (not pending).
REQ-013 SHALL have port rd_b_sel  input  4  side-B source: 0-7 register, 8 immediate, 9-15 none.
REQ-014 SHALL have port imm8  input  WORD_SIZE  immediate operand for rd_b_sel=8.
REQ-015 SHALL have port rd_b_data  output  WORD_SIZE  side-B operand.
REQ-016 SHALL have port rd_b_ready  output  1  side-B operand valid.
REQ-017 SHALL have port busy  output  8  per-register pending-write scoreboard, bit i = register i.

Function
REQ-018 SHALL hold 8 registers of WORD_SIZE bits plus 8 busy bits.
REQ-019 SHALL, when wr_valid=1, write wr_data into register wr_sel and clear busy[wr_sel] at the clock edge; writes are always accepted, including to non-busy registers.
REQ-020 SHALL drive lock_ready = !busy[lock_sel] combinationally, independent of lock_valid.
REQ-021 SHALL set busy[lock_sel] at the clock edge when lock_valid=1 and lock_ready=1; lock to a busy register has no effect.
REQ-022 SHALL, on same-cycle write and lock to the same index, store wr_data and leave busy bit set (lock wins over clear); lock_ready in that cycle follows REQ-020 (pre-edge busy), so lock on a busy register being written is refused.
REQ-023 SHALL read combinationally (zero latency): rd_a_data = reg[rd_a_sel], rd_a_ready = !busy[rd_a_sel].
REQ-024 SHALL drive rd_b_data = reg[rd_b_sel[2:0]], rd_b_ready = !busy[...] for rd_b_sel 0-7; imm8 with ready=1 for 8; all-zero with ready=1 for 9-15.
REQ-025 SHALL make written data visible on read ports the cycle after the write edge (without bypass, see REQ-029).
REQ-026 SHALL never produce X on any output after reset regardless of select values.

Reset
REQ-027 SHALL, while rst_n=0, asynchronously force all registers to 0 and busy to 8'h00; outputs then reflect reset state (rd_*_data=0, rd_*_ready=1, lock_ready=1).
REQ-028 SHALL, when reset asserts mid-operation, discard all pending locks and in-flight writes of that cycle; first edge after release performs normal operation.

Configuration
REQ-029 SHALL, when macro REGFILE_BYPASS_EN is defined, forward wr_data to a read port whose register select equals wr_sel while wr_valid=1, forcing that port's ready=1 in the same cycle (rd_b only for rd_b_sel 0-7); busy bit and stored value update per REQ-019 unchanged.
REQ-030 SHALL, without REGFILE_BYPASS_EN, have no forwarding path; read ports reflect stored state only.

Verification
REQ-031 SHALL cover: reset, then write 8'hA5 to r3; next cycle rd_a_sel=3 -> rd_a_data=8'hA5, rd_a_ready=1, busy=8'h00.
REQ-032 SHALL cover: lock r5, next cycle rd_b_sel=5 -> rd_b_ready=0, busy=8'h20, lock_sel=5 -> lock_ready=0; write 8'h3C to r5 -> next cycle rd_b_ready=1, data 8'h3C, busy=8'h00.
REQ-033 SHALL cover: rd_b_sel=8, imm8=8'h7E -> rd_b_data=8'h7E, ready=1; rd_b_sel=12 -> rd_b_data=0, ready=1.
REQ-034 SHALL cover: r2 not busy, same-cycle lock r2 and write 8'h11 to r2 -> after edge reg[2]=8'h11, busy[2]=1.
REQ-035 SHALL cover: with REGFILE_BYPASS_EN, r6 busy, wr_valid=1 wr_sel=6 wr_data=8'h99, rd_a_sel=6 -> same cycle rd_a_data=8'h99, rd_a_ready=1; without macro -> rd_a_ready=0, old data.
REQ-036 SHALL cover: lock r1 and r4, write r1=8'h55, assert rst_n=0 mid-cycle -> immediately busy=8'h00, all reads 0 with ready=1.

Source files
------------

// File: rtl/register_file_2r1w.sv
// Eight-entry register file: two combinational read ports, one write port and a per-register busy scoreboard.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module register_file_2r1w #(
  parameter int WORD_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_valid,
  input  logic [2:0]           wr_sel,
  input  logic [WORD_SIZE-1:0] wr_data,
  input  logic                 lock_valid,
  input  logic [2:0]           lock_sel,
  output logic                 lock_ready,
  input  logic [2:0]           rd_a_sel,
  output logic [WORD_SIZE-1:0] rd_a_data,
  output logic                 rd_a_ready,
  input  logic [3:0]           rd_b_sel,
  input  logic [WORD_SIZE-1:0] imm8,
  output logic [WORD_SIZE-1:0] rd_b_data,
  output logic                 rd_b_ready,
  output logic [7:0]           busy
);

  logic [WORD_SIZE-1:0] r_regs [0:7];
  logic [7:0]           r_busy;

  logic [7:0]           w_clr_mask;
  logic [7:0]           w_set_mask;
  logic [7:0]           w_busy_next;
  logic                 w_lock_ready;
  logic [WORD_SIZE-1:0] w_a_data;
  logic                 w_a_ready;
  logic [WORD_SIZE-1:0] w_b_data;
  logic                 w_b_ready;

  // A lock is only granted on a register that is idle before the edge.
  always_comb begin
    w_lock_ready = ~r_busy[lock_sel];
  end

  // Scoreboard update: a write clears its bit, a granted lock sets it and wins on collision.
  always_comb begin
    w_clr_mask = 8'h00;
    w_set_mask = 8'h00;
    if (wr_valid) begin
      w_clr_mask = 8'h01 << wr_sel;
    end else begin
      w_clr_mask = 8'h00;
    end
    if (lock_valid && w_lock_ready) begin
      w_set_mask = 8'h01 << lock_sel;
    end else begin
      w_set_mask = 8'h00;
    end
    w_busy_next = (r_busy & ~w_clr_mask) | w_set_mask;
  end

  // Register storage and busy bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        r_regs[i] <= {WORD_SIZE{1'b0}};
      end
      r_busy <= 8'h00;
    end else begin
      if (wr_valid) begin
        r_regs[wr_sel] <= wr_data;
      end
      r_busy <= w_busy_next;
    end
  end

  // Side-A read port.
  always_comb begin
    w_a_data  = r_regs[rd_a_sel];
    w_a_ready = ~r_busy[rd_a_sel];
`ifdef REGFILE_BYPASS_EN
    if (wr_valid && (wr_sel == rd_a_sel)) begin
      w_a_data  = wr_data;
      w_a_ready = 1'b1;
    end else begin
      w_a_data  = r_regs[rd_a_sel];
      w_a_ready = ~r_busy[rd_a_sel];
    end
`endif
  end

  // Side-B read port: register, immediate, or a constant zero for unused selects.
  always_comb begin
    w_b_data  = {WORD_SIZE{1'b0}};
    w_b_ready = 1'b1;
    case (rd_b_sel)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7: begin
        w_b_data  = r_regs[rd_b_sel[2:0]];
        w_b_ready = ~r_busy[rd_b_sel[2:0]];
`ifdef REGFILE_BYPASS_EN
        if (wr_valid && (wr_sel == rd_b_sel[2:0])) begin
          w_b_data  = wr_data;
          w_b_ready = 1'b1;
        end else begin
          w_b_data  = r_regs[rd_b_sel[2:0]];
          w_b_ready = ~r_busy[rd_b_sel[2:0]];
        end
`endif
      end
      4'd8: begin
        w_b_data  = imm8;
        w_b_ready = 1'b1;
      end
      default: begin
        w_b_data  = {WORD_SIZE{1'b0}};
        w_b_ready = 1'b1;
      end
    endcase
  end

  assign lock_ready = w_lock_ready;
  assign rd_a_data  = w_a_data;
  assign rd_a_ready = w_a_ready;
  assign rd_b_data  = w_b_data;
  assign rd_b_ready = w_b_ready;
  assign busy       = r_busy;

endmodule
